// File: rtl/result_display_ctrl.sv
// rtl/result_display_ctrl.sv - binary to seven-segment display controller (double-dabble)
module result_display_ctrl #(
   parameter int IN_W        = 30,
   parameter int DIGITS      = 10,
   parameter int SIGNED      = 0,
   parameter int BLANK_LZ    = 1,
   parameter int SEG_ACT_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_W-1:0]       value,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int ND = DIGITS - SIGNED;
   localparam int BW = 4 * ND;
   localparam int CW = $clog2(IN_W + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [BW-1:0]       bcd_q, bcd_adj;
   logic [IN_W-1:0]     mag_q, mag_in;
   logic                sign_q, sign_in, ovf_sticky_q, ovf_q;
   logic [7*DIGITS-1:0] seg_q, seg_fmt;
   int                  msd, dash_pos;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   // Most negative input negates to itself, which is the correct unsigned magnitude.
   assign sign_in = (SIGNED != 0) && value[IN_W-1];
   assign mag_in  = sign_in ? (~value + IN_W'(1)) : value;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONVERT;
         CONVERT: if (cnt_q == CW'(1)) state_d = FORMAT;
         FORMAT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < ND; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      msd = 0;
      for (int i = 0; i < ND; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      dash_pos = (BLANK_LZ != 0) ? msd + 1 : DIGITS - 1;
      seg_fmt  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf_sticky_q)
            seg_fmt[7*i +: 7] = 7'h40;
         else if (sign_q && i == dash_pos)
            seg_fmt[7*i +: 7] = 7'h40;
         else if (i < ND && (BLANK_LZ == 0 || i <= msd))
            seg_fmt[7*i +: 7] = seg7(4'(bcd_q >> (4*i)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bcd_q        <= '0;
         mag_q        <= '0;
         sign_q       <= 1'b0;
         ovf_sticky_q <= 1'b0;
         ovf_q        <= 1'b0;
         seg_q        <= '0;
         done         <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sign_q       <= sign_in;
                  mag_q        <= mag_in;
                  bcd_q        <= '0;
                  cnt_q        <= CW'(IN_W);
                  ovf_sticky_q <= 1'b0;
               end
            end
            CONVERT: begin
               {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
               cnt_q          <= cnt_q - CW'(1);
               // A 1 leaving the top nibble means the value needs more than ND digits.
               if (bcd_adj[BW-1]) ovf_sticky_q <= 1'b1;
            end
            FORMAT: begin
               seg_q <= seg_fmt;
               ovf_q <= ovf_sticky_q;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state_q != IDLE);
   assign overflow = ovf_q;
   assign seg      = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// tb/tb_result_display_ctrl.sv - scoreboard bench for result_display_ctrl over five parameter sets
module tb_result_display_ctrl;

   typedef struct {
      logic [69:0] seg;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start, busy, done, ovf;
   logic [63:0] val [5];
   logic [69:0] seg0;
   logic [27:0] seg1, seg2, seg3, seg4;
   logic [69:0] seg_w [5];
   exp_t        sb [5][$];
   int          inw [5] = '{30, 30, 8, 30, 8};
   int          st_cyc [5];
   int          bcnt [5];
   int          cyc = 0;
   int          passes = 0;
   int          total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   result_display_ctrl #(.IN_W(30), .DIGITS(10), .SIGNED(0), .BLANK_LZ(1), .SEG_ACT_LOW(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .value(val[0][29:0]),
      .busy(busy[0]), .done(done[0]), .overflow(ovf[0]), .seg(seg0));
   result_display_ctrl #(.IN_W(30), .DIGITS(4), .SIGNED(0), .BLANK_LZ(1), .SEG_ACT_LOW(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .value(val[1][29:0]),
      .busy(busy[1]), .done(done[1]), .overflow(ovf[1]), .seg(seg1));
   result_display_ctrl #(.IN_W(8), .DIGITS(4), .SIGNED(1), .BLANK_LZ(1), .SEG_ACT_LOW(0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .value(val[2][7:0]),
      .busy(busy[2]), .done(done[2]), .overflow(ovf[2]), .seg(seg2));
   result_display_ctrl #(.IN_W(30), .DIGITS(4), .SIGNED(0), .BLANK_LZ(0), .SEG_ACT_LOW(1)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start[3]), .value(val[3][29:0]),
      .busy(busy[3]), .done(done[3]), .overflow(ovf[3]), .seg(seg3));
   result_display_ctrl #(.IN_W(8), .DIGITS(4), .SIGNED(1), .BLANK_LZ(0), .SEG_ACT_LOW(0)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start[4]), .value(val[4][7:0]),
      .busy(busy[4]), .done(done[4]), .overflow(ovf[4]), .seg(seg4));

   assign seg_w[0] = seg0;
   assign seg_w[1] = 70'(seg1);
   assign seg_w[2] = 70'(seg2);
   assign seg_w[3] = 70'(seg3);
   assign seg_w[4] = 70'(seg4);

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 5; k++) begin
         if (!rst_n) bcnt[k] = 0;
         else if (busy[k]) bcnt[k]++;
         if (done[k]) begin
            if (sb[k].size() == 0) begin
               chk($sformatf("dut%0d unexpected done", k), 70'(done[k]), 70'd0);
            end else begin
               exp_t e;
               e = sb[k].pop_front();
               chk($sformatf("dut%0d seg", k), seg_w[k], e.seg);
               chk($sformatf("dut%0d overflow", k), 70'(ovf[k]), 70'(e.ovf));
               chk($sformatf("dut%0d latency", k), 70'(cyc - st_cyc[k]), 70'(inw[k] + 1));
               chk($sformatf("dut%0d busy cycles", k), 70'(bcnt[k]), 70'(inw[k] + 1));
            end
            bcnt[k] = 0;
         end
      end
   end

   task automatic issue(input int k, input logic [63:0] v, input logic [69:0] s, input logic o);
      int   g = 0;
      exp_t e;
      while (busy[k] && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (busy[k]) chk($sformatf("dut%0d idle timeout", k), 70'(busy[k]), 70'd0);
      start[k] = 1'b1;
      val[k]   = v;
      e.seg    = s;
      e.ovf    = o;
      sb[k].push_back(e);
      @(posedge clk); #1;
      st_cyc[k] = cyc;
      start[k]  = 1'b0;
   endtask

   function automatic int pending();
      int n = 0;
      for (int k = 0; k < 5; k++) n += sb[k].size();
      return n;
   endfunction

   task automatic drain();
      int g = 0;
      while (pending() != 0 && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      if (pending() != 0) chk("drain timeout", 70'(pending()), 70'd0);
      repeat (40) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = '0;
      for (int k = 0; k < 5; k++) val[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("dut%0d reset busy", k), 70'(busy[k]), 70'd0);
         chk($sformatf("dut%0d reset done", k), 70'(done[k]), 70'd0);
         chk($sformatf("dut%0d reset overflow", k), 70'(ovf[k]), 70'd0);
         chk($sformatf("dut%0d reset seg", k), seg_w[k], (k == 3) ? 70'h0FFFFFFF : 70'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(0, 64'd0, 70'h3F, 1'b0);
      issue(0, 64'd1073741823,
            {7'h06, 7'h3F, 7'h07, 7'h4F, 7'h07, 7'h66, 7'h06, 7'h7F, 7'h5B, 7'h4F}, 1'b0);
      issue(0, 64'd42, {7'h66, 7'h5B}, 1'b0);
      issue(0, 64'd1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

      issue(1, 64'd12345, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
      issue(1, 64'd99, {7'h00, 7'h00, 7'h6F, 7'h6F}, 1'b0);
      issue(1, 64'd9999, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0);
      issue(1, 64'd10000, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);

      issue(2, 64'h80, {7'h40, 7'h06, 7'h5B, 7'h7F}, 1'b0);
      issue(2, 64'hFB, {7'h00, 7'h00, 7'h40, 7'h6D}, 1'b0);
      issue(2, 64'h05, {7'h00, 7'h00, 7'h00, 7'h6D}, 1'b0);
      issue(2, 64'h7F, {7'h00, 7'h06, 7'h5B, 7'h07}, 1'b0);
      issue(2, 64'hFF, {7'h00, 7'h00, 7'h40, 7'h06}, 1'b0);
      issue(2, 64'h00, {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0);

      issue(3, 64'd42, {7'h40, 7'h40, 7'h19, 7'h24}, 1'b0);
      issue(3, 64'd0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      issue(3, 64'd10000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1);

      issue(4, 64'hFB, {7'h40, 7'h3F, 7'h3F, 7'h6D}, 1'b0);
      issue(4, 64'h05, {7'h00, 7'h3F, 7'h3F, 7'h6D}, 1'b0);
      drain();

      // Starts while busy must be dropped: only the value 7 may appear.
      issue(0, 64'd7, 70'h07, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start[0] = 1'b1;
         val[0]   = 64'd123;
         @(posedge clk); #1;
         start[0] = 1'b0;
      end
      drain();

      // Abort mid-conversion with reset.
      start[0] = 1'b1;
      val[0]   = 64'd555;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort busy", 70'(busy[0]), 70'd0);
      chk("abort done", 70'(done[0]), 70'd0);
      chk("abort seg", seg_w[0], 70'h0);
      chk("abort overflow", 70'(ovf[0]), 70'd0);
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      issue(0, 64'd1000, {7'h06, 7'h3F, 7'h3F, 7'h3F}, 1'b0);
      drain();

      for (int k = 0; k < 5; k++)
         chk($sformatf("dut%0d scoreboard empty", k), 70'(sb[k].size()), 70'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
